// File: rtl/breadboard_inverse.sv
`default_nettype none
// ============================================================================
//  Module      : breadboard_inverse
//  Description : Sequential inverse of the 4-input / 10-output breadboard
//                function network. A 10-bit observed output pattern is
//                accepted in IDLE. SEARCH then evaluates the forward function
//                on candidate codes 0..15, one per clock, and stops at the
//                lowest code whose output equals the pattern. DONE holds the
//                result until the consumer takes it.
//
//  Ports       : clk        in   1   sole clock, rising edge
//                rst_n      in   1   synchronous, active-low reset
//                in_valid   in   1   pattern offered
//                in_ready   out  1   block idle, can accept
//                pattern    in  10   observed vector, bit k = function rk
//                out_valid  out  1   result held
//                out_ready  in   1   consumer takes result
//                code       out  4   recovered input {w,x,y,z}
//                found      out  1   1 = code matches, 0 = no code matches
//
//  Revision    : 1.0  initial release
// ============================================================================
module breadboard_inverse (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] pattern,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] code,
    output logic       found
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SEARCH = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    localparam logic [3:0] c_IDX_LAST  = 4'd15;

    logic [1:0] r_state;
    logic [1:0] w_state_next;

    logic [3:0] r_idx;
    logic [9:0] r_pattern;
    logic [3:0] r_code;
    logic       r_found;

    logic [9:0] w_fwd;
    logic       w_match;

    // ------------------------------------------------------------------------
    // Forward breadboard function evaluated on the current candidate.
    // Bit order of the candidate: idx[3]=w, idx[2]=x, idx[1]=y, idx[0]=z.
    // ------------------------------------------------------------------------
    logic w_w;
    logic w_x;
    logic w_y;
    logic w_z;

    assign w_w = r_idx[3];
    assign w_x = r_idx[2];
    assign w_y = r_idx[1];
    assign w_z = r_idx[0];

    // Number of ones among the four inputs; drives the "exactly two" and
    // "odd count" outputs.
    logic [2:0] w_ones;
    assign w_ones = {2'b00, w_w} + {2'b00, w_x} + {2'b00, w_y} + {2'b00, w_z};

    always_comb begin
        w_fwd    = 10'd0;
        w_fwd[0] = (w_w & w_x) | (w_w & w_z) | (w_x & w_y) | (w_y & w_z);
        w_fwd[1] = (w_w & w_x) | (w_x & w_z) | (w_y & w_z);
        w_fwd[2] = (w_w & w_y & w_z) | (w_w & w_x & w_z)
                 | (w_x & w_y & w_z) | (w_w & w_x & w_y);
        w_fwd[3] = (w_w & w_z) | (w_x & w_y);
        w_fwd[4] = w_y & w_z;
        w_fwd[5] = (~w_w & ~w_x) | (~w_y & ~w_z);
        w_fwd[6] = (~w_w & ~w_x &  w_y)
                 | (~w_w & ~w_y &  w_z)
                 | ( w_x & ~w_y &  w_z)
                 | ( w_w & ~w_x & ~w_y & ~w_z);
        w_fwd[7] = (w_ones == 3'd2);
        w_fwd[8] = w_y & w_z;
        w_fwd[9] = w_ones[0];
    end

    assign w_match = (w_fwd == r_pattern);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (in_valid) begin
                    w_state_next = c_ST_SEARCH;
                end
            end
            c_ST_SEARCH: begin
                // A match or exhausting the last candidate both end the search.
                if (w_match || (r_idx == c_IDX_LAST)) begin
                    w_state_next = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (out_ready) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers: captured pattern, candidate index and result.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx     <= 4'd0;
            r_pattern <= 10'd0;
            r_code    <= 4'd0;
            r_found   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_pattern <= pattern;
                        r_idx     <= 4'd0;
                    end
                end
                c_ST_SEARCH: begin
                    if (w_match) begin
                        r_code  <= r_idx;
                        r_found <= 1'b1;
                    end else if (r_idx == c_IDX_LAST) begin
                        r_code  <= 4'd0;
                        r_found <= 1'b0;
                    end else begin
                        // Never wraps: the last-candidate branch above stops it.
                        r_idx <= r_idx + 4'd1;
                    end
                end
                default: begin
                    // DONE holds the result unchanged.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output decode: handshake flags from state, result from registers only.
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            c_ST_IDLE: in_ready  = 1'b1;
            c_ST_DONE: out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    assign code  = r_code;
    assign found = r_found;

endmodule
`default_nettype wire

// File: tb/tb_breadboard_inverse.sv
`default_nettype none
// ============================================================================
//  Module      : tb_breadboard_inverse
//  Description : Self-checking bench for breadboard_inverse. Directed vector
//                table, exhaustive sweep, backpressure and mid-search reset
//                sequences, and random patterns checked against a behavioural
//                model of the forward function and its lowest-code inverse.
//
//  Revision    : 1.0  initial release
// ============================================================================
module tb_breadboard_inverse;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] pattern;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] code;
    logic       found;

    int n_checks;
    int n_fail;

    breadboard_inverse u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pattern   (pattern),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .code      (code),
        .found     (found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    function automatic logic [9:0] m_fwd(input int c);
        int w, x, y, z, ones;
        logic [9:0] r;
        w = (c >> 3) & 1;
        x = (c >> 2) & 1;
        y = (c >> 1) & 1;
        z = c & 1;
        ones = w + x + y + z;
        r = '0;
        r[0] = (w*x + w*z + x*y + y*z) != 0;
        r[1] = (w*x + x*z + y*z) != 0;
        r[2] = (w*y*z + w*x*z + x*y*z + w*x*y) != 0;
        r[3] = (w*z + x*y) != 0;
        r[4] = (y*z) != 0;
        r[5] = ((1-w)*(1-x) + (1-y)*(1-z)) != 0;
        r[6] = ((1-w)*(1-x)*y + (1-w)*(1-y)*z + x*(1-y)*z + w*(1-x)*(1-y)*(1-z)) != 0;
        r[7] = (ones == 2);
        r[8] = (y*z) != 0;
        r[9] = (ones % 2) == 1;
        return r;
    endfunction

    // Lowest code producing the pattern; -1 when none does.
    function automatic int m_inv(input logic [9:0] p);
        for (int j = 0; j < 16; j++) begin
            if (m_fwd(j) == p) return j;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Offer a pattern, then wait (bounded) for out_valid. Returns latency in
    // edges after the accept edge. out_ready is held low during the search.
    task automatic offer(input logic [9:0] p, output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        pattern   = p;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pattern  = 10'($urandom);
        chk("busy_in_ready", int'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Consume the held result and confirm return to IDLE.
    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("idle_in_ready", int'(in_ready), 1);
        chk("idle_out_valid", int'(out_valid), 0);
    endtask

    task automatic run_and_check(input string name, input logic [9:0] p,
                                 input int e_code, input int e_found,
                                 input int e_lat);
        int lat;
        offer(p, lat);
        chk({name, "_latency"}, lat, e_lat);
        chk({name, "_code"}, int'(code), e_code);
        chk({name, "_found"}, int'(found), e_found);
        consume();
    endtask

    typedef struct {
        logic [9:0] pat;
        int         e_code;
        int         e_found;
        int         e_lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int lat;
        int e;
        logic [9:0] p;

        vecs[0] = '{pat: 10'h020, e_code: 0,  e_found: 1, e_lat: 1};
        vecs[1] = '{pat: 10'h0C2, e_code: 5,  e_found: 1, e_lat: 6};
        vecs[2] = '{pat: 10'h11F, e_code: 15, e_found: 1, e_lat: 16};
        vecs[3] = '{pat: 10'h3FF, e_code: 0,  e_found: 0, e_lat: 16};
        vecs[4] = '{pat: 10'h010, e_code: 0,  e_found: 0, e_lat: 16};

        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        pattern   = 10'd0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_code", int'(code), 0);
        chk("rst_found", int'(found), 0);

        // Directed table
        for (int i = 0; i < 5; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].pat, vecs[i].e_code,
                          vecs[i].e_found, vecs[i].e_lat);
        end

        // Backpressure: result held, input ignored while DONE
        offer(10'h0C2, lat);
        chk("bp_latency", lat, 6);
        @(negedge clk);
        in_valid = 1'b1;
        pattern  = 10'h020;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_code", int'(code), 5);
            chk("bp_found", int'(found), 1);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        consume();
        repeat (2) @(posedge clk);
        #1;
        chk("bp_no_new_req", int'(in_ready), 1);
        chk("bp_no_new_out", int'(out_valid), 0);

        // Sweep all 16 codes
        for (int i = 0; i < 16; i++) begin
            p = m_fwd(i);
            e = m_inv(p);
            run_and_check($sformatf("sweep%0d", i), p, e, 1, e + 1);
        end

        // Reset during SEARCH at idx=7 (no-match pattern keeps it searching)
        offer(10'h3FF, lat);
        // offer() leaves us already past the end of the search; start over
        consume();
        @(negedge clk);
        in_valid = 1'b1;
        pattern  = 10'h3FF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("mid_still_busy", int'(out_valid), 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_code", int'(code), 0);
        chk("mid_rst_found", int'(found), 0);
        repeat (12) @(posedge clk);
        #1;
        chk("mid_rst_quiet", int'(out_valid), 0);

        // Randomized: half reachable patterns, half arbitrary
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) p = m_fwd(int'($urandom_range(0, 15)));
            else            p = 10'($urandom);
            e = m_inv(p);
            run_and_check($sformatf("rand%0d", i), p,
                          (e < 0) ? 0 : e, (e < 0) ? 0 : 1,
                          (e < 0) ? 16 : e + 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
